sar_adc_ctrl: RTL

SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

---
 rtl/sar_adc_pkg.sv | 16 +
 rtl/sar_adc_outbuf.sv | 38 +++
 rtl/sar_adc_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/sar_adc_pkg.sv
// Shared types and default sizing for the SAR ADC controller.
// Imported by the controller FSM and its output buffer.
package sar_adc_pkg;

    localparam int ADC_W_DEF         = 10;
    localparam int TRACK_CYCLES_DEF  = 4;
    localparam int SETTLE_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        CONV  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sar_adc_outbuf.sv
// Result register with valid/ready handshake and sticky overrun flag.
// A load in the same cycle as a handshake keeps valid high with new data.
module sar_adc_outbuf
    import sar_adc_pkg::*;
#(
    parameter int ADC_W = ADC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [ADC_W-1:0] din,
    input  logic             ready,
    input  logic             clr_ovr,
    output logic [ADC_W-1:0] data,
    output logic             valid,
    output logic             overrun
);

    logic set_ovr;

    assign set_ovr = load & valid & ~ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load) begin
                data <= din;
            end
            valid   <= load | (valid & ~ready);
            // set beats clear when both land on the same edge
            overrun <= set_ovr | (overrun & ~clr_ovr);
        end
    end

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: track, MSB-first bit trials,
// then hand the result to the output buffer.
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int ADC_W         = ADC_W_DEF,
    parameter int TRACK_CYCLES  = TRACK_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cmp,
    output logic [ADC_W-1:0] dac_code,
    output logic             track,
    output logic [ADC_W-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam int BW = (ADC_W > 1) ? $clog2(ADC_W) : 1;
    localparam logic [7:0]    TRK_LAST = 8'(TRACK_CYCLES - 1);
    localparam logic [7:0]    SET_LAST = 8'(SETTLE_CYCLES);
    localparam logic [BW-1:0] MSB      = BW'(ADC_W - 1);

    state_t           state;
    logic [7:0]       cnt;
    logic [BW-1:0]    bit_idx;
    logic [ADC_W-1:0] code;
    logic             load;

    // code carries resolved upper bits plus the bit under trial
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            code    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en) state <= TRACK;
                end
                TRACK: begin
                    if (cnt == TRK_LAST) begin
                        state   <= CONV;
                        cnt     <= '0;
                        bit_idx <= MSB;
                        code    <= '0;
                        code[ADC_W-1] <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                CONV: begin
                    if (cnt == SET_LAST) begin
                        cnt <= '0;
                        code[bit_idx] <= cmp;
                        if (bit_idx == '0) begin
                            state <= DONE;
                        end else begin
                            bit_idx <= bit_idx - BW'(1);
                            code[bit_idx - BW'(1)] <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    state <= en ? TRACK : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dac_code = (state == CONV) ? code : '0;
    assign track    = (state == TRACK);
    assign load     = (state == DONE);

    sar_adc_outbuf #(
        .ADC_W (ADC_W)
    ) u_outbuf (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .din     (code),
        .ready   (ready),
        .clr_ovr (clr_ovr),
        .data    (data),
        .valid   (valid),
        .overrun (overrun)
    );

endmodule
